// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
//   Multi-cycle sequencer for the MIPS datapath. It steps each instruction
//   through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK. This lets the register file,
//   the ALU and one shared instruction/data memory be reused across cycles.
//   It drives every datapath select and enable, and waits on mem_ready in the
//   memory states. It counts retired instructions and raises a sticky fault on
//   an illegal opcode or a memory timeout.
//
// Ports
//   clk, reset             clock; asynchronous active-high reset
//   run                    1 = execute, 0 = stop at the next instruction boundary
//   opcode, funct          IR[31:26] / IR[5:0], valid from DECODE onward
//   zero                   ALU zero flag (BRANCH)
//   mem_ready              shared memory finished the current access
//   state                  current state encoding (debug)
//   pc_write/pc_src        PC load and PC source select
//   ir_write, iord         IR load, memory address select (0 PC, 1 ALU)
//   mem_read/mem_write     memory request strobes
//   reg_write/reg_dst/mem_to_reg   register file write control
//   alu_src_a/alu_src_b/alu_op     ALU operand and operation selects
//   busy, fault            activity flag, sticky fault flag
//   instr_count            retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             mem_ready,
   output logic [3:0]       state,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             ir_write,
   output logic             iord,
   output logic             mem_read,
   output logic             mem_write,
   output logic             reg_write,
   output logic [1:0]       reg_dst,
   output logic [1:0]       mem_to_reg,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [2:0]       alu_op,
   output logic             busy,
   output logic             fault,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_EXEC_R = 4'd3,
      S_EXEC_I = 4'd4,
      S_ADDR   = 4'd5,
      S_MEM_RD = 4'd6,
      S_MEM_WR = 4'd7,
      S_WB_ALU = 4'd8,
      S_WB_MEM = 4'd9,
      S_BRANCH = 4'd10,
      S_JUMP   = 4'd11,
      S_HALT   = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_HALT  = 6'h3F;
   localparam logic [5:0] FN_JR    = 6'h08;

   // Last wait count still allowed before giving up (MEM_TIMEOUT is 1..255).
   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t           state_q, state_d;
   logic             fault_q, fault_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       wait_q, wait_d;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         fault_q <= 1'b0;
         cnt_q   <= '0;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         fault_q <= fault_d;
         cnt_q   <= cnt_d;
         wait_q  <= wait_d;
      end
   end

   // Next-state logic. The wait counter returns to zero whenever the FSM is
   // not stalled in a memory state, so every entry to FETCH/MEM_RD/MEM_WR
   // starts from zero. A mem_ready on the last allowed cycle wins over timeout.
   always_comb begin
      logic retire;
      logic mem_wait;
      state_d  = state_q;
      fault_d  = fault_q;
      cnt_d    = cnt_q;
      wait_d   = '0;
      retire   = 1'b0;
      mem_wait = 1'b0;

      case (state_q)
         S_IDLE:   if (run) state_d = S_FETCH;
         S_FETCH:  if (mem_ready) state_d = S_DECODE;
                   else mem_wait = 1'b1;
         S_DECODE: begin
            case (opcode)
               OP_RTYPE: state_d = (funct == FN_JR) ? S_JUMP : S_EXEC_R;
               OP_LW, OP_SW: state_d = S_ADDR;
               OP_BEQ: state_d = S_BRANCH;
               OP_J, OP_JAL: state_d = S_JUMP;
               OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_EXEC_I;
               OP_HALT: state_d = S_HALT;
               default: begin
                  state_d = S_HALT;
                  fault_d = 1'b1;
               end
            endcase
         end
         S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
         S_ADDR:   state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD: if (mem_ready) state_d = S_WB_MEM;
                   else mem_wait = 1'b1;
         S_MEM_WR: if (mem_ready) retire = 1'b1;
                   else mem_wait = 1'b1;
         S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: retire = 1'b1;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_IDLE;
      endcase

      if (mem_wait) begin
         if (wait_q >= WAIT_LAST) begin
            state_d = S_HALT;
            fault_d = 1'b1;
         end else begin
            wait_d = wait_q + 8'd1;
         end
      end

      if (retire) begin
         cnt_d   = cnt_q + CNT_W'(1);
         state_d = run ? S_FETCH : S_IDLE;
      end
   end

   // Output decode from the current state (plus IR fields, zero and mem_ready)
   always_comb begin
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      ir_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 2'b00;
      mem_to_reg = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 3'b000;
      busy       = (state_q != S_IDLE) && (state_q != S_HALT);

      case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE: alu_src_b = 2'b11;
         S_EXEC_R: begin
            alu_src_a = 1'b1;
            alu_op    = 3'b010;
         end
         S_EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            case (opcode)
               OP_ANDI: alu_op = 3'b011;
               OP_ORI:  alu_op = 3'b100;
               OP_SLTI: alu_op = 3'b101;
               default: alu_op = 3'b000;
            endcase
         end
         S_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEM_RD: begin
            iord     = 1'b1;
            mem_read = 1'b1;
         end
         S_MEM_WR: begin
            iord      = 1'b1;
            mem_write = 1'b1;
         end
         S_WB_ALU: begin
            reg_write = 1'b1;
            reg_dst   = (opcode == OP_RTYPE) ? 2'b01 : 2'b00;
         end
         S_WB_MEM: begin
            reg_write  = 1'b1;
            mem_to_reg = 2'b01;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = 3'b001;
            pc_src    = 2'b01;
            pc_write  = zero;
         end
         S_JUMP: begin
            pc_write = 1'b1;
            pc_src   = (opcode == OP_RTYPE) ? 2'b11 : 2'b10;
            if (opcode == OP_JAL) begin
               reg_write  = 1'b1;
               reg_dst    = 2'b10;
               mem_to_reg = 2'b10;
            end
         end
         default: ;
      endcase
   end

   assign state       = state_q;
   assign fault       = fault_q;
   assign instr_count = cnt_q;

endmodule
